uart_rx_sampler: RTL
====================

// Module: uart_rx_sampler
// PURPOSE
//  UART 8N1 receiver; direct consumer of the divider's clk_sampling output (SAMPLE_RATE ticks per bit).
//  Runs entirely on clk: clk_sampling is used only as a data signal, and its rising edge forms a 1-cycle sample_tick.
//  Finds the start bit and majority-votes each bit at mid-bit.
//  Delivers bytes through a 1-entry valid/ready holding register; flags framing errors and overruns.
// PARAMETERS
//  SAMPLE_RATE  10  sample ticks per bit; must be >= 4 (same value as the divider's SAMPLE_RATE)
//  DATA_BITS    8   data bits per frame, sent LSB first
// PORTS
//  clk           in   1          system clock
//  rst           in   1          asynchronous, active-low reset
//  clk_sampling  in   1          oversample clock from the divider; registered and edge-detected only
//  rx            in   1          serial line, idles high, asynchronous to clk
//  rx_data       out  DATA_BITS  received byte, valid while rx_valid=1
//  rx_valid      out  1          holding register full
//  rx_ready      in   1          consumer accepts when rx_valid&rx_ready
//  frame_err     out  1          1-cycle pulse: stop bit voted 0
//  overrun       out  1          1-cycle pulse: byte completed while holding register full and not draining
//  busy          out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
//    Also: rx synchroniser flops=1, clk_sampling delay flop=1 (no spurious tick at reset release).
//  rx goes through a 2-flop synchroniser -> rx_s.
//  sample_tick = cs_q & ~cs_qq, where cs_q and cs_qq are successive registered copies of clk_sampling.
//  All FSM activity advances only on cycles with sample_tick=1; tick_cnt counts 0..SAMPLE_RATE-1 within a bit.
//  MID = SAMPLE_RATE/2 (5 for the default). Vote samples are taken at tick_cnt MID-1, MID, MID+1.
//    Bit value = majority of the 3 samples, resolved at tick MID+1.
//  States:
//   IDLE:  on a tick with rx_s=0 -> START with tick_cnt=1; the detecting tick counts as tick 0.
//   START: at MID+1, vote=1 -> false start, back to IDLE with no output.
//          Otherwise, at tick SAMPLE_RATE-1 -> DATA with bit_idx=0, tick_cnt=0.
//   DATA:  at MID+1, shift the vote into shreg from the MSB side (LSB-first line order).
//          At tick SAMPLE_RATE-1: bit_idx++; after DATA_BITS bits -> STOP.
//   STOP:  at MID+1 -> IDLE in the same transition (mid-stop resync allows back-to-back frames).
//          vote=1: deliver shreg.  vote=0: frame_err pulses; byte discarded.
//  Delivery happens on the clk edge after the STOP vote tick:
//    - rx_valid=0, or rx_valid&rx_ready in the same cycle: load rx_data, rx_valid=1.
//    - otherwise: old byte kept, new byte dropped, overrun pulses once.
//  rx_valid&rx_ready with no delivery in that cycle -> rx_valid=0 next edge; rx_data holds its last value.
//  A ready/valid handshake costs no ticks; the FSM never stalls.
//  Async reset mid-frame aborts immediately; the next falling rx after release starts a new frame.
//  busy = (state != IDLE).
//  Widths: tick_cnt is $clog2(SAMPLE_RATE) bits; bit_idx is $clog2(DATA_BITS+1) bits; no wrap beyond the limits above.
// STRUCTURE
//  Shared package uart_pkg:
//    - state encoding IDLE/START/DATA/STOP (2 bits)
//    - default SAMPLE_RATE and DATA_BITS
//    - function for MID
//  Sub-module uart_sync_edge: 2-flop rx synchroniser plus the clk_sampling edge detector, async active-low reset.
//  Top level: FSM, counters, vote logic, shift register, output holding register.
// TESTING (clk_sampling driven directly, period 4 clk; SAMPLE_RATE=10, so 1 bit = 40 clk)
//  1. Frame 0xA5 (start, 10100101 sent LSB first, stop), rx_ready=0
//     -> rx_valid=1, rx_data=0xA5, held until rx_ready=1 for one cycle; frame_err=0 throughout.
//  2. rx low for 3 ticks, then high -> no rx_valid; busy returns to 0 after the START vote.
//  3. Frame 0x3C with stop bit=0 -> one-cycle frame_err; rx_valid stays 0; next good frame 0x3C is received.
//  4. Back-to-back 0x11, 0x22 with rx_ready=0
//     -> rx_data=0x11 and exactly one overrun pulse; after rx_ready=1, rx_valid drops with no new data.
//  5. Frame 0xFF with a single-tick low glitch at tick MID of each data bit -> rx_data=0xFF (2-of-3 vote).
//  6. rst=0 during data bit 3 -> all outputs 0 and busy=0 with no clk edge needed;
//     after release, frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// State encoding, default parameters and the mid-bit helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int DEF_SAMPLE_RATE = 10;
    localparam int DEF_DATA_BITS   = 8;

    function automatic int mid_of(input int sample_rate);
        return sample_rate / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Valid/ready byte delivery bundle between the receiver and its consumer.
// master = receiver side, slave = consumer side.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync_edge.sv
// rx double-flop synchroniser and clk_sampling rising-edge detector.
// Flops reset high so reset release never yields a spurious tick or start.
module uart_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic clk_sampling,
    output logic rx_s,
    output logic sample_tick
);
    logic rx_m;
    logic cs_q;
    logic cs_qq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            cs_q  <= 1'b1;
            cs_qq <= 1'b1;
        end else begin
            rx_m  <= rx;
            rx_s  <= rx_m;
            cs_q  <= clk_sampling;
            cs_qq <= cs_q;
        end
    end

    assign sample_tick = cs_q & ~cs_qq;

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: oversampled start detect, 3-sample mid-bit vote,
// single-entry valid/ready holding register with framing/overrun flags.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int SAMPLE_RATE = DEF_SAMPLE_RATE,
    parameter int DATA_BITS   = DEF_DATA_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_sampling,
    input  logic rx,
    uart_rx_sampler_if.master bus,
    output logic frame_err,
    output logic overrun,
    output logic busy
);
    localparam int TW  = $clog2(SAMPLE_RATE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int MID = mid_of(SAMPLE_RATE);

    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [TW-1:0] T_M1   = TW'(MID - 1);
    localparam logic [TW-1:0] T_MID  = TW'(MID);
    localparam logic [TW-1:0] T_P1   = TW'(MID + 1);
    localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic rx_s;
    logic sample_tick;

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic                 vote;
    logic                 deliver;
    logic                 stop_bad;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;

    uart_sync_edge u_sync (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .clk_sampling (clk_sampling),
        .rx_s         (rx_s),
        .sample_tick  (sample_tick)
    );

    // Third sample is the live one, so the vote resolves at MID+1.
    assign vote = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        deliver  = 1'b0;
        stop_bad = 1'b0;
        if (sample_tick) begin
            tick_d = (tick_q == T_LAST) ? '0 : tick_q + T_ONE;
            if (tick_q == T_M1)  s0_d = rx_s;
            if (tick_q == T_MID) s1_d = rx_s;
            unique case (state_q)
                IDLE: begin
                    tick_d = '0;
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = T_ONE;
                    end
                end
                START: begin
                    if (tick_q == T_P1 && vote) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else if (tick_q == T_LAST) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (tick_q == T_P1)
                        shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (tick_q == T_LAST) begin
                        bit_d = bit_q + B_ONE;
                        if (bit_q == B_LAST) state_d = STOP;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a following start edge is not missed.
                    if (tick_q == T_P1) begin
                        state_d  = IDLE;
                        tick_d   = '0;
                        deliver  = vote;
                        stop_bad = ~vote;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!valid_q || bus.rx_ready) begin
                    data_q  <= shreg_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data  = data_q;
    assign bus.rx_valid = valid_q;
    assign busy         = (state_q != IDLE);

endmodule
